// File: rtl/splinker_pump_ctrl.sv
// splinker_pump_ctrl: turns a level open request into a timed valve/pump sequence
// with lead, lag, minimum-run and minimum-rest guards. Max-run lockout: SPLINKER_MAX_ON_EN.
//
// state | meaning
// IDLE  | valve closed, pump off, waiting for a request
// PRIME | valve open ahead of pump start
// RUN   | pump running, valve open
// DRAIN | pump stopped, valve held open
// REST  | valve closed, anti-short-cycle rest
module splinker_pump_ctrl #(
  parameter int LEAD_TICKS    = 2,
  parameter int MIN_ON_TICKS  = 10,
  parameter int MAX_ON_TICKS  = 600,
  parameter int LAG_TICKS     = 2,
  parameter int MIN_OFF_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       splinker_request,
  input  logic       inhibit,
  input  logic       fault_clear,
  output logic       valve_open,
  output logic       pump_on,
  output logic       busy,
  output logic [2:0] state,
  output logic       overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_REST  = 3'd4;

  localparam logic [15:0] LEAD_LAST    = 16'(LEAD_TICKS - 1);
  localparam logic [15:0] MIN_ON_VAL   = 16'(MIN_ON_TICKS);
  localparam logic [15:0] LAG_LAST     = 16'(LAG_TICKS - 1);
  localparam logic [15:0] MIN_OFF_LAST = 16'(MIN_OFF_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q;
  logic        overrun_set;

  // Timer restarts on every state change; the tick of the exit edge is not carried over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        timer_q <= '0;
      else if (tick && state_q != S_IDLE && timer_q != 16'hFFFF)
        timer_q <= timer_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    overrun_set = 1'b0;
    case (state_q)
      S_IDLE:
        if (splinker_request && !inhibit && !overrun) state_d = S_PRIME;
      S_PRIME:
        if (inhibit || !splinker_request)           state_d = S_DRAIN;
        else if (tick && timer_q == LEAD_LAST)      state_d = S_RUN;
      S_RUN:
        if (inhibit)                                state_d = S_DRAIN;
`ifdef SPLINKER_MAX_ON_EN
        else if (tick && timer_q == 16'(MAX_ON_TICKS - 1)) begin
          state_d     = S_DRAIN;
          overrun_set = 1'b1;
        end
`endif
        else if (!splinker_request && timer_q >= MIN_ON_VAL) state_d = S_DRAIN;
      S_DRAIN:
        if (tick && timer_q == LAG_LAST)            state_d = S_REST;
      S_REST:
        if (tick && timer_q == MIN_OFF_LAST)        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valve_open = 1'b0;
    pump_on    = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_PRIME: valve_open = 1'b1;
      S_RUN: begin
        valve_open = 1'b1;
        pump_on    = 1'b1;
      end
      S_DRAIN: valve_open = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef SPLINKER_MAX_ON_EN
  logic overrun_q;

  // A new overrun in the same cycle as a clear keeps the lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overrun_q <= 1'b0;
    else if (overrun_set)  overrun_q <= 1'b1;
    else if (fault_clear)  overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;
`else
  logic unused_cfg;

  assign overrun    = 1'b0;
  assign unused_cfg = fault_clear | overrun_set | (MAX_ON_TICKS == 0);
`endif

endmodule
